// File: rtl/arki_pipe_pkg.sv
// Shared types and constants for the LEGv8 pipeline controller.
package arki_pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pctrl_state_t;

    localparam int XZR = 31;

    localparam int BANK_IFID  = 0;
    localparam int BANK_IDEX  = 1;
    localparam int BANK_EXMEM = 2;
    localparam int BANK_MEMWB = 3;
    localparam int NUM_BANKS  = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline bank enable/clear sequencer with load-use stall, branch flush,
// data-memory wait and debug halt/drain.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  RUN    | normal issue; hazards handled per cycle
//  DRAIN  | fetch suppressed, retiring in-flight work, drain_cnt counts down
//  HALTED | pipeline frozen, halted=1, waits for halt_req to drop
module pipeline_ctrl
    import arki_pipe_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_branch_taken,
    input  logic             dmem_busy,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             exmem_clr,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [REG_W-1:0] XZR_ADDR = REG_W'(XZR);

    pctrl_state_t state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;

    logic                  load_use;
    logic                  ld_stall;
    logic                  pc_en_c;
    logic                  halted_c;
    logic [NUM_BANKS-1:0]  en_c;
    logic [BANK_EXMEM:0]   clr_c;
    logic                  stall_inc;
    logic                  flush_inc;

    assign load_use = ex_memread && (ex_rd != XZR_ADDR) &&
                      ((ex_rd == id_rn) || (ex_rd == id_rm));
    // A taken branch squashes the dependent instruction, so it is not a stall.
    assign ld_stall = load_use && !mem_branch_taken;

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        pc_en_c   = 1'b0;
        halted_c  = 1'b0;
        en_c      = '0;
        clr_c     = '0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        if (state == HALTED) begin
            halted_c = 1'b1;
            if (!halt_req)
                state_nxt = RUN;
        end else if (dmem_busy) begin
            // Memory wait freezes everything, including the drain countdown.
            stall_inc = 1'b1;
        end else begin
            pc_en_c = 1'b1;
            en_c    = '1;
            if (mem_branch_taken) begin
                clr_c     = '1;
                flush_inc = 1'b1;
            end else if (ld_stall) begin
                pc_en_c             = 1'b0;
                en_c[BANK_IFID]     = 1'b0;
                clr_c[BANK_IDEX]    = 1'b1;
                stall_inc           = 1'b1;
            end

            if (state == RUN) begin
                if (halt_req) begin
                    state_nxt = DRAIN;
                    drain_nxt = DW'(DRAIN_CYCLES);
                end
            end else begin
                // IF/ID keeps its held instruction during a load-use stall.
                if (!mem_branch_taken && !ld_stall) begin
                    pc_en_c          = 1'b0;
                    clr_c[BANK_IFID] = 1'b1;
                end
                if (!ld_stall) begin
                    drain_nxt = drain_cnt - DW'(1);
                    if (drain_cnt == DW'(1))
                        state_nxt = HALTED;
                end
                if (!halt_req) begin
                    state_nxt = RUN;
                    drain_nxt = '0;
                end
            end
        end

        if (!reset) begin
            pc_en_c  = 1'b0;
            halted_c = 1'b0;
            en_c     = '0;
            clr_c    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    assign pc_en     = pc_en_c;
    assign ifid_en   = en_c[BANK_IFID];
    assign idex_en   = en_c[BANK_IDEX];
    assign exmem_en  = en_c[BANK_EXMEM];
    assign memwb_en  = en_c[BANK_MEMWB];
    assign ifid_clr  = clr_c[BANK_IFID];
    assign idex_clr  = clr_c[BANK_IDEX];
    assign exmem_clr = clr_c[BANK_EXMEM];
    assign halted    = halted_c;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a narrow-counter copy exercises saturation.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rn = '0, id_rm = '0, ex_rd = '0;
    logic       ex_memread = 1'b0, mem_branch_taken = 1'b0, dmem_busy = 1'b0, halt_req = 1'b0;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_clr, s_idex_clr, s_exmem_clr, s_halted;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    // {pc_en, ifid/idex/exmem/memwb_en, ifid/idex/exmem_clr, halted}
    localparam logic [8:0] O_ZERO   = 9'b0_0000_000_0;
    localparam logic [8:0] O_NORMAL = 9'b1_1111_000_0;
    localparam logic [8:0] O_BUSY   = 9'b0_0000_000_0;
    localparam logic [8:0] O_BRANCH = 9'b1_1111_111_0;
    localparam logic [8:0] O_LDUSE  = 9'b0_0111_010_0;
    localparam logic [8:0] O_DRAIN  = 9'b0_1111_100_0;
    localparam logic [8:0] O_HALTED = 9'b0_0000_000_1;

    typedef struct {
        logic [8:0] v;
        string      tag;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
        .dmem_busy(dmem_busy), .halt_req(halt_req),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
        .exmem_clr(exmem_clr), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
        .dmem_busy(dmem_busy), .halt_req(halt_req),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
        .memwb_en(s_memwb_en), .ifid_clr(s_ifid_clr), .idex_clr(s_idex_clr),
        .exmem_clr(s_exmem_clr), .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    wire [8:0] obs   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                        ifid_clr, idex_clr, exmem_clr, halted};
    wire [8:0] obs_s = {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en,
                        s_ifid_clr, s_idex_clr, s_exmem_clr, s_halted};

    // Drive one cycle of inputs, sample the Mealy outputs mid-cycle, end just after the edge.
    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic br, input logic busy,
                         input logic halt, input logic [8:0] exp_v, input string tag);
        exp_t e;
        ex_memread = mr; ex_rd = rd; id_rn = rn; id_rm = rm;
        mem_branch_taken = br; dmem_busy = busy; halt_req = halt;
        sbq.push_back('{v: exp_v, tag: tag});
        @(negedge clk);
        checks++;
        assert (sbq.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed %b expected %b", e.tag, obs, e.v);
            end
            checks++;
            assert (obs_s === e.v) else begin
                errors++;
                $error("FAIL %s_narrow observed %b expected %b", e.tag, obs_s, e.v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input int es, input int ef, input string tag);
        logic [31:0] es_w, ef_w;
        logic [2:0]  es_n, ef_n;
        es_w = 32'(es);
        ef_w = 32'(ef);
        es_n = (es > 7) ? 3'd7 : 3'(es);
        ef_n = (ef > 7) ? 3'd7 : 3'(ef);
        checks++;
        assert (stall_cnt === es_w) else begin
            errors++;
            $error("FAIL %s stall_cnt observed %0d expected %0d", tag, stall_cnt, es_w);
        end
        checks++;
        assert (flush_cnt === ef_w) else begin
            errors++;
            $error("FAIL %s flush_cnt observed %0d expected %0d", tag, flush_cnt, ef_w);
        end
        checks++;
        assert (s_stall_cnt === es_n) else begin
            errors++;
            $error("FAIL %s sat_stall observed %0d expected %0d", tag, s_stall_cnt, es_n);
        end
        checks++;
        assert (s_flush_cnt === ef_n) else begin
            errors++;
            $error("FAIL %s sat_flush observed %0d expected %0d", tag, s_flush_cnt, ef_n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held: outputs forced low despite a normal-looking input set.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_ZERO, "in_reset");
        reset = 1'b1;
        chk_cnt(0, 0, "after_reset");

        // Load-use detection and the XZR exception.
        drive(1, 5'd3, 5'd3, 5'd0, 0, 0, 0, O_LDUSE, "lduse_rn");
        chk_cnt(1, 0, "lduse_rn_cnt");
        drive(1, 5'd31, 5'd0, 5'd31, 0, 0, 0, O_NORMAL, "xzr");
        drive(1, 5'd3, 5'd4, 5'd5, 0, 0, 0, O_NORMAL, "no_match");
        drive(1, 5'd7, 5'd0, 5'd7, 0, 0, 0, O_LDUSE, "lduse_rm");
        drive(0, 5'd3, 5'd3, 5'd3, 0, 0, 0, O_NORMAL, "not_load");
        chk_cnt(2, 0, "lduse_cnt");

        // Branch overrides load-use.
        drive(1, 5'd3, 5'd3, 5'd0, 1, 0, 0, O_BRANCH, "br_lduse");
        chk_cnt(2, 1, "br_lduse_cnt");

        // Busy beats branch; flush fires once busy drops.
        for (int i = 0; i < 3; i++)
            drive(0, 5'd0, 5'd0, 5'd0, 1, 1, 0, O_BUSY, "busy_br");
        chk_cnt(5, 1, "busy_cnt");
        drive(0, 5'd0, 5'd0, 5'd0, 1, 0, 0, O_BRANCH, "br_after_busy");
        chk_cnt(5, 2, "br_after_busy_cnt");

        // Halt with a branch mid-drain: four drain cycles, halted on the fifth.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_NORMAL, "halt_req_run");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_DRAIN, "drain1");
        drive(0, 5'd0, 5'd0, 5'd0, 1, 0, 1, O_BRANCH, "drain2_br");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_DRAIN, "drain3");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_DRAIN, "drain4");
        drive(1, 5'd3, 5'd3, 5'd0, 1, 1, 1, O_HALTED, "halted_ign");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_HALTED, "halted_hold");
        chk_cnt(5, 3, "halted_cnt");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_HALTED, "halt_release");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_NORMAL, "resume_run");

        // One load-use in drain extends it to five cycles.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_NORMAL, "halt2_run");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_DRAIN, "d2_1");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_DRAIN, "d2_2");
        drive(1, 5'd9, 5'd9, 5'd0, 0, 0, 1, O_LDUSE, "d2_lduse");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_DRAIN, "d2_3");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_DRAIN, "d2_4");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_HALTED, "d2_halted");
        chk_cnt(6, 3, "d2_cnt");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_HALTED, "d2_release");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_NORMAL, "d2_resume");

        // Drain abort: back to RUN, never halted.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_NORMAL, "ab_run");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_DRAIN, "ab_d1");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_DRAIN, "ab_d2");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_DRAIN, "ab_drop");
        for (int i = 0; i < 4; i++)
            drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_NORMAL, "ab_after");

        // Reset mid-drain.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_NORMAL, "rs_run");
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_DRAIN, "rs_d1");
        reset = 1'b0;
        drive(0, 5'd0, 5'd0, 5'd0, 1, 0, 1, O_ZERO, "rs_low");
        chk_cnt(0, 0, "rs_cnt");
        reset = 1'b1;
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_NORMAL, "rs_resume");

        // Saturation on the narrow instance.
        for (int i = 0; i < 10; i++)
            drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_BUSY, "sat_busy");
        chk_cnt(10, 0, "sat_stall");
        for (int i = 0; i < 9; i++)
            drive(0, 5'd0, 5'd0, 5'd0, 1, 0, 0, O_BRANCH, "sat_br");
        chk_cnt(10, 9, "sat_flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
